// File: rtl/seq_logic_pkg.sv
// Shared types for the sequential bit-slice logic unit: operation encoding,
// controller states and the slice-counter width helper.
package seq_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Slice counter width: clog2 of the slice count, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator for one SLICE-wide chunk of the operands.
module logic_slice
  import seq_logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_e              op,
  output logic [SLICE-1:0] y
);

  // Apply the selected bitwise operation to the slice.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Sequential logic unit: applies AND/OR/XOR/NOR to two WIDTH-bit operands,
// SLICE bits per clock, through a single shared logic_slice instance.
// Optional feature macro: SEQ_LOGIC_ZERO_FLAG_EN enables the registered
// result-is-zero flag; without it the zero port is tied to 0.
module seq_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);

  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("seq_logic_unit: WIDTH must be a positive multiple of SLICE");
  end

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              r_op;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic [CW-1:0]    r_cnt;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_y;
  logic             w_accept;
  logic             w_last;

  // A start is only honoured when no operation is in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(N - 1));

  // Select the operand slice addressed by the counter.
  assign w_a_slice = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_slice = r_b[r_cnt*SLICE +: SLICE];

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (w_a_slice),
    .b  (w_b_slice),
    .op (r_op),
    .y  (w_y)
  );

  // Result with the current slice merged in; committed on each RUN edge.
  always_comb begin
    w_res_next = r_res;
    w_res_next[r_cnt*SLICE +: SLICE] = w_y;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is written with <= so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, slice counter and result accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= OP_AND;
      r_res <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_op  <= op_e'(op);
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_res <= w_res_next;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Res = r_res;

`ifdef SEQ_LOGIC_ZERO_FLAG_EN
  logic r_zero;

  // Zero flag: evaluated on the final slice, held until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_zero <= 1'b0;
    else if (w_accept)                     r_zero <= 1'b0;
    else if ((r_state == S_RUN) && w_last) r_zero <= (w_res_next == '0);
  end

  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit (32/8 with a cycle model, 16/16 directed).
module tb_seq_logic_unit;

  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

`ifdef SEQ_LOGIC_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b, res;
  logic          busy, done, zero;

  logic          start2;
  logic [1:0]    op2;
  logic [15:0]   a2, b2, res2;
  logic          busy2, done2, zero2;

  always #5 clk = ~clk;

  seq_logic_unit #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .Res(res), .busy(busy), .done(done), .zero(zero)
  );

  seq_logic_unit #(.WIDTH(16), .SLICE(16)) dut_w16 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .A(a2), .B(b2),
    .Res(res2), .busy(busy2), .done(done2), .zero(zero2)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;
  int n_busy  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_age: -1 = no operation in flight; 0..N-1 = slices already written;
  // N = result complete (done cycle).
  int           m_age  = -1;
  logic [W-1:0] m_full = '0;
  logic [W-1:0] m_res  = '0;
  logic         m_zero = 1'b0;

  function automatic logic [W-1:0] full_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age = -1; m_full = '0; m_res = '0; m_zero = 1'b0;
    end else if ((m_age < 0 || m_age == N) && start) begin
      m_age = 0; m_full = full_op(op, a, b); m_res = '0; m_zero = 1'b0;
    end else if (m_age == N) begin
      m_age = -1;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == N) begin
        m_res  = m_full;
        m_zero = ZF && (m_full == '0);
      end else begin
        m_res = m_full & W'((64'd1 << (m_age * S)) - 64'd1);
      end
    end
  end

  // Per-cycle comparison of the 32/8 instance against the model.
  initial begin
    wait (reset === 1'b1);
    forever begin
      @(posedge clk);
      #2;
      check("busy", busy, 64'(m_age >= 0 && m_age < N));
      check("done", done, 64'(m_age == N));
      check("res",  res,  64'(m_res));
      check("zero", zero, 64'(m_zero));
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, done, 1);
  endtask

  initial begin
    int d0, b0;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("rst_res",  res,  0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 0);
    reset = 1'b0;

    // AND: four busy cycles, one done cycle.
    b0 = n_busy;
    start_op(2'b00, 32'hF0F0_FF00, 32'hFF00_F0F0);
    wait_done("and");
    check("and_res", res, 32'hF000_F000);
    check("and_zero", zero, 0);
    check("and_busy_cycles", n_busy - b0, 4);
    @(negedge clk);
    check("and_done_one_cycle", done, 0);

    // NOR to zero: flag depends on build.
    start_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_done("nor");
    check("nor_res", res, 0);
    check("nor_zero", zero, 64'(ZF));

    // XOR with operand change and start pulse during RUN.
    d0 = n_done;
    start_op(2'b10, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    a = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("xor");
    check("xor_res", res, 0);
    repeat (6) @(negedge clk);
    check("xor_single_done", n_done - d0, 1);
    check("xor_no_restart", busy, 0);

    // OR with start held high: back-to-back every 5 cycles.
    d0 = n_done;
    @(negedge clk);
    op = 2'b01; a = 32'h8000_0001; b = 32'h0000_FF00; start = 1'b1;
    repeat (15) @(negedge clk);
    start = 1'b0;
    check("or_done_at_15", done, 1);
    check("or_res", res, 32'h8000_FF01);
    repeat (8) @(negedge clk);
    check("or_done_count", n_done - d0, 3);

    // Reset after second RUN cycle aborts the operation.
    start_op(2'b00, 32'hAAAA_5555, 32'hFFFF_0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_res",  res,  0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    d0 = n_done;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    start_op(2'b00, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    wait_done("post_abort");
    check("post_abort_res", res, 32'h0F0F_0F0F);

    // Single-slice build: done on the second edge after start.
    @(negedge clk);
    op2 = 2'b00; a2 = 16'hABCD; b2 = 16'h00FF; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("w16_busy_e1", busy2, 1);
    check("w16_done_e1", done2, 0);
    @(negedge clk);
    check("w16_done_e2", done2, 1);
    check("w16_busy_e2", busy2, 0);
    check("w16_res", res2, 16'h00CD);
    check("w16_zero", zero2, 0);
    @(negedge clk);
    check("w16_done_pulse", done2, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Res  output  WIDTH  result register.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse, Res valid.
REQ-012 zero  output  1  result-is-zero flag (see Configuration).

Function
REQ-013 FSM states IDLE, RUN, DONE; N = WIDTH/SLICE.
REQ-014 IDLE or DONE with start=1 at an edge: latch A, B, op into internal registers, clear Res to 0, slice counter to 0, enter RUN.
REQ-015 DONE with start=0: return to IDLE at next edge; done high only while in DONE.
REQ-016 RUN: each edge writes Res[(k+1)*SLICE-1 : k*SLICE] = op applied bitwise to latched A/B slice k, k = counter, then counter increments.
REQ-017 RUN exits to DONE on the edge processing slice N-1; latency start-sampled edge to done-high = N+1 edges (32/8: done high in 5th cycle after start cycle).
REQ-018 A, B, op changes during RUN SHALL NOT affect the result; start during RUN SHALL be ignored.
REQ-019 Res holds its value in DONE and IDLE until the next accepted start; slices not yet processed read 0 during RUN.
REQ-020 SLICE = WIDTH SHALL be legal: N=1, single RUN cycle.
REQ-021 Counter width = clog2(N), minimum 1 bit; no wrap beyond N-1.

Reset
REQ-022 reset high SHALL immediately force IDLE, Res=0, counter=0, latched operands/op=0, busy=0, done=0, zero=0.
REQ-023 reset mid-RUN SHALL abort the operation with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-024 Macro SEQ_LOGIC_ZERO_FLAG_EN defined: zero registered, set 1 together with entry to DONE iff final Res==0, held until next accepted start (cleared then) or reset.
REQ-025 Macro undefined: zero port present, tied constant 0; no flag logic synthesised.

Structure
REQ-026 Package seq_logic_pkg SHALL hold the op encoding enum (OP_AND, OP_OR, OP_XOR, OP_NOR) and state enum (S_IDLE, S_RUN, S_DONE).
REQ-027 One combinational sub-module logic_slice (parameter SLICE; inputs a, b, op; output y) SHALL compute one slice; instantiated once, muxed by counter.

Verification
REQ-028 Reset then start, op=AND, A=0xF0F0_FF00, B=0xFF00_F0F0 -> busy 4 cycles, done one cycle, Res=0xF000_F000, zero=0.
REQ-029 op=NOR, A=0xFFFF_FFFF, B=0 -> Res=0x0000_0000, zero=1 with macro, zero=0 without.
REQ-030 op=XOR, A=0x1234_5678, B=0x1234_5678 started; change A to 0xFFFF_FFFF and pulse start during RUN -> Res=0, single done, no restart.
REQ-031 op=OR, A=0x8000_0001, B=0x0000_FF00 with start held high continuously -> Res=0x8000_FF01 on each done, back-to-back operations every 5 cycles (start re-accepted in DONE).
REQ-032 Assert reset after 2nd RUN cycle -> Res=0, busy=0, no done; subsequent AND of 0xFFFF_FFFF, 0x0F0F_0F0F -> Res=0x0F0F_0F0F.
REQ-033 WIDTH=16, SLICE=16, op=AND, A=0xABCD, B=0x00FF -> done high on 2nd edge after start, Res=0x00CD.
